core_fetch: RTL and testbench
=============================

Name: core_fetch

Overview:
- Instruction-fetch front end; the consumer side of the next-PC/flush interface driven by the branch/redirect unit.
- Holds the fetch PC and issues in-order requests to instruction memory.
- Buffers returned instructions and presents them to the IF/ID register with pc and pc4.
- On flush, redirects to next_pc and discards every in-flight and buffered instruction from the old path.

Parameters:
- RESET_PC, 64'h0, fetch address loaded at reset.
- DEPTH, 4, maximum outstanding requests plus buffered instructions (power of two, ≥2).

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous active-low reset
- next_pc  input  64  redirect target from branch unit; valid when flush=1
- flush  input  1  redirect request; kill all old-path fetches
- stall  input  1  IF/ID not accepting this cycle
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  64  fetch address
- imem_resp_valid  input  1  instruction returned; in order, always accepted
- imem_resp_data  input  32  returned instruction
- if_valid  output  1  if_inst/if_pc/if_pc4 valid
- if_inst  output  32  instruction
- if_pc  output  64  address of if_inst
- if_pc4  output  64  if_pc + 4

Behaviour:
- All state updates on posedge clk. Reset (reset_n=0, sampled at edge):
  - pc_q <= RESET_PC.
  - Outstanding queue and instruction buffer emptied; all kill bits cleared.
  - Outputs read 0 the following cycle: imem_req_valid=0, if_valid=0, if_inst=0, if_pc=0, if_pc4=0.
  - Reset overrides flush, stall and responses in the same cycle.
- Credit rule: imem_req_valid = (outstanding + buffered < DEPTH) && !flush. imem_req_addr = pc_q.
- Request handshake (valid && ready):
  - Push {pc_q, kill=0} into the outstanding queue.
  - pc_q <= pc_q + 4 (64-bit wrap at 2^64).
- Response:
  - Pop the outstanding queue head.
  - If kill=0, push {pc, imem_resp_data} into the instruction buffer; if kill=1, drop it.
  - A response with an empty outstanding queue is a protocol error; assertion only, no RTL action.
- Output:
  - if_valid = buffer non-empty && !flush.
  - if_inst/if_pc come from the buffer head; if_pc4 = if_pc + 4 (wraps).
  - When if_valid && !stall, the head is popped at the edge.
- Flush (flush=1, reset_n=1), taking effect at the edge:
  - pc_q <= next_pc; instruction buffer cleared.
  - Every valid outstanding entry gets kill=1, including one popped by a same-cycle response, which is dropped.
  - No request is issued and no instruction is delivered in the flush cycle.
  - First new-path request is possible the next cycle.
  - Back-to-back flushes: each re-kills all outstanding entries; the last next_pc wins.
- Priority: reset > flush > stall.
- Same-cycle buffer push and pop is legal when the buffer is full. The credit rule guarantees the buffer and outstanding queue never overflow.
- Zero-bubble steady state: with 1-cycle memory latency and stall=0, one if_valid per cycle after a 2-cycle startup.
- Stall holds all if_* outputs stable. Issue continues until credits run out.

Optional Feature:
- Macro: CORE_FETCH_MISALIGN_EN.
- When defined:
  - Extra output if_misalign (1 bit) is registered per buffer entry; it is 1 when the entry's pc[1:0] != 0.
  - Misaligned pc_q issues no memory request. Exactly one entry with if_inst=32'h0 and if_misalign=1 is inserted, then issue halts until the next flush or reset.
- When undefined:
  - Port is absent.
  - pc[1:0] is ignored; imem_req_addr is pc_q unchanged.

Test Plan:
- Reset with RESET_PC=64'h100, then release; memory at 1-cycle latency, stall=0 -> requests 0x100, 0x104, 0x108…; if_valid from cycle 2 with if_pc=0x100, if_pc4=0x104, one instruction per cycle.
- Hold stall=1 for 6 cycles -> if_* stable; exactly DEPTH=4 requests outstanding+buffered, then imem_req_valid=0. Release stall -> instructions 0x100..0x10C delivered in order, none lost.
- Hold 3 requests outstanding, imem_req_ready held high, then assert flush with next_pc=0x2000 for 1 cycle -> the 3 old responses are dropped; first if_valid shows if_pc=0x2000; no old-path instruction appears.
- Flush at 0x3000, then flush at 0x4000 on the next cycle, with responses delayed 4 cycles -> only the 0x4000 path is delivered.
- Assert reset_n=0 while flush=1 and a response arrives -> state equals RESET_PC; if_valid=0 next cycle.
- With CORE_FETCH_MISALIGN_EN defined, flush to 0x2002 -> one entry with if_pc=0x2002, if_misalign=1, if_inst=0; no imem request until flush to 0x3000.

Source files
------------

// File: rtl/core_fetch.sv
// core_fetch -- instruction-fetch front end.
//
// Holds the fetch PC, issues in-order requests to instruction memory, keeps
// a small queue of outstanding request PCs, buffers returned instructions and
// presents them to the IF/ID register together with pc and pc + 4. A flush
// redirects fetch to next_pc and discards every in-flight and buffered
// instruction that belongs to the old path.
//
// Parameters:
//   RESET_PC  fetch address loaded at reset
//   DEPTH     outstanding requests plus buffered instructions (power of two, >= 2)
//
// Ports:
//   clk, reset_n        core clock, synchronous active-low reset
//   next_pc, flush      redirect target and redirect request
//   stall               IF/ID not accepting this cycle
//   imem_req_*          request channel to instruction memory
//   imem_resp_*         in-order response channel (always accepted)
//   if_valid/inst/pc/pc4  instruction presented to IF/ID
//   if_misalign         only with CORE_FETCH_MISALIGN_EN: entry pc[1:0] != 0
//
// Optional feature macro: CORE_FETCH_MISALIGN_EN. When defined, a misaligned
// fetch PC issues no memory request; a single zero instruction flagged as
// misaligned is inserted instead and fetch halts until the next flush/reset.

module core_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic [63:0] if_pc4
`ifdef CORE_FETCH_MISALIGN_EN
  ,
  output logic        if_misalign
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_T = (CW + 1)'(DEPTH);

  logic [63:0]      pc_q, pc_d;

  // Outstanding queue: PC of each issued request plus its kill bit.
  logic [63:0]      oPc_q [DEPTH];
  logic [DEPTH-1:0] oKill_q, oKill_d;
  logic [AW-1:0]    oHead_q, oHead_d, oTail_q, oTail_d;
  logic [CW-1:0]    oCnt_q, oCnt_d;

  // Instruction buffer feeding IF/ID.
  logic [63:0]      bPc_q [DEPTH];
  logic [31:0]      bInst_q [DEPTH];
  logic [AW-1:0]    bHead_q, bHead_d, bTail_q, bTail_d;
  logic [CW-1:0]    bCnt_q, bCnt_d;

  logic             credit, reqFire, respPop, respKeep;
  logic             bPush, bPop, bNotEmpty;
  logic [63:0]      pushPc;
  logic [31:0]      pushInst;

`ifdef CORE_FETCH_MISALIGN_EN
  logic [DEPTH-1:0] bMis_q;
  logic             misHalt_q, misHalt_d;
  logic             misPc, insMis;
`endif

  // Request/response handshakes and the buffer push/pop decisions. A request
  // needs a free credit so neither queue can overflow; while reset is held
  // nothing is offered to memory. A response always pops the outstanding
  // head, but only reaches the buffer if its entry was not killed and no
  // flush is clearing the buffer in this same cycle.
  always_comb begin
    credit = ({1'b0, oCnt_q} + {1'b0, bCnt_q}) < DEPTH_T;
`ifdef CORE_FETCH_MISALIGN_EN
    misPc          = pc_q[1:0] != 2'b00;
    imem_req_valid = reset_n && credit && !flush && !misPc;
    // The marker entry waits for the outstanding queue to drain so that it
    // lands in the buffer behind all older instructions.
    insMis         = reset_n && credit && !flush && misPc && !misHalt_q &&
                     (oCnt_q == '0);
`else
    imem_req_valid = reset_n && credit && !flush;
`endif
    imem_req_addr = pc_q;
    reqFire       = imem_req_valid && imem_req_ready;
    respPop       = imem_resp_valid && (oCnt_q != '0);
    respKeep      = respPop && !oKill_q[oHead_q] && !flush;

    pushPc   = oPc_q[oHead_q];
    pushInst = imem_resp_data;
    bPush    = respKeep;
`ifdef CORE_FETCH_MISALIGN_EN
    if (insMis) begin
      pushPc   = pc_q;
      pushInst = '0;
      bPush    = 1'b1;
    end
`endif

    bNotEmpty = bCnt_q != '0;
    if_valid  = bNotEmpty && !flush;
    bPop      = if_valid && !stall;
  end

  // IF/ID view of the buffer head; everything reads zero while it is empty.
  always_comb begin
    if_inst = bNotEmpty ? bInst_q[bHead_q] : '0;
    if_pc   = bNotEmpty ? bPc_q[bHead_q] : '0;
    if_pc4  = bNotEmpty ? bPc_q[bHead_q] + 64'd4 : '0;
`ifdef CORE_FETCH_MISALIGN_EN
    if_misalign = bNotEmpty ? bMis_q[bHead_q] : 1'b0;
`endif
  end

  // Next-state for PC, queue pointers/counters and kill bits. A flush wins
  // over everything but reset: it loads next_pc, empties the buffer and
  // marks every outstanding slot as killed. Marking empty slots too is
  // harmless because a fresh push always clears the slot's kill bit.
  always_comb begin
    pc_d = pc_q;
    if (flush)        pc_d = next_pc;
    else if (reqFire) pc_d = pc_q + 64'd4;

    oTail_d = reqFire ? oTail_q + AW'(1) : oTail_q;
    oHead_d = respPop ? oHead_q + AW'(1) : oHead_q;
    oCnt_d  = oCnt_q + CW'(reqFire) - CW'(respPop);
    oKill_d = oKill_q;
    if (reqFire) oKill_d[oTail_q] = 1'b0;
    if (flush)   oKill_d = '1;

    if (flush) begin
      bHead_d = '0;
      bTail_d = '0;
      bCnt_d  = '0;
    end else begin
      bHead_d = bPop  ? bHead_q + AW'(1) : bHead_q;
      bTail_d = bPush ? bTail_q + AW'(1) : bTail_q;
      bCnt_d  = bCnt_q + CW'(bPush) - CW'(bPop);
    end

`ifdef CORE_FETCH_MISALIGN_EN
    misHalt_d = misHalt_q;
    if (flush)       misHalt_d = 1'b0;
    else if (insMis) misHalt_d = 1'b1;
`endif
  end

  // Control state register with synchronous reset; reset overrides flush,
  // stall and any response arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      oHead_q <= '0;
      oTail_q <= '0;
      oCnt_q  <= '0;
      oKill_q <= '0;
      bHead_q <= '0;
      bTail_q <= '0;
      bCnt_q  <= '0;
`ifdef CORE_FETCH_MISALIGN_EN
      misHalt_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      oHead_q <= oHead_d;
      oTail_q <= oTail_d;
      oCnt_q  <= oCnt_d;
      oKill_q <= oKill_d;
      bHead_q <= bHead_d;
      bTail_q <= bTail_d;
      bCnt_q  <= bCnt_d;
`ifdef CORE_FETCH_MISALIGN_EN
      misHalt_q <= misHalt_d;
`endif
    end
  end

  // Payload storage needs no reset: occupancy counters decide validity.
  always_ff @(posedge clk) begin
    if (reqFire) oPc_q[oTail_q] <= pc_q;
    if (reset_n && bPush) begin
      bPc_q[bTail_q]   <= pushPc;
      bInst_q[bTail_q] <= pushInst;
`ifdef CORE_FETCH_MISALIGN_EN
      bMis_q[bTail_q]  <= pushPc[1:0] != 2'b00;
`endif
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  respWithoutRequest: assert property (@(posedge clk) disable iff (!reset_n)
    imem_resp_valid |-> (oCnt_q != '0));

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch -- directed self-checking bench for core_fetch.
// A small in-order memory model with programmable latency answers requests;
// every instruction word is derived from its address so delivered data can be
// checked against the delivered pc.

`timescale 1ns/1ps

module tb_core_fetch;

  logic        clk = 1'b0;
  logic        reset_n, flush, stall;
  logic [63:0] next_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc, if_pc4;
`ifdef CORE_FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  core_fetch #(.RESET_PC(64'h100), .DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .next_pc        (next_pc),
    .flush          (flush),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
`ifdef CORE_FETCH_MISALIGN_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [63:0] delivered[$];
  int          cycNum, memLat, reqCount;
  int          assertCount, failCount;

  // Instruction word stored at a given address.
  function automatic logic [31:0] memData(input logic [63:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs and any due memory response just after the
  // edge, then sample handshakes and deliveries mid-cycle.
  task automatic applyStimulus(input logic rstN, input logic fl,
                               input logic [63:0] npc, input logic st);
    @(posedge clk);
    #1;
    cycNum++;
    reset_n         = rstN;
    flush           = fl;
    next_pc         = npc;
    stall           = st;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (memQ.size() > 0 && memQ[0].due <= cycNum) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memData(memQ[0].addr);
      void'(memQ.pop_front());
    end
    if (!rstN) memQ.delete();
    #3;
    if (imem_req_valid && imem_req_ready) begin
      memQ.push_back('{addr: imem_req_addr, due: cycNum + memLat});
      reqCount++;
    end
    if (if_valid && !stall) begin
      delivered.push_back(if_pc);
      checkOutput("pc4", if_pc4, if_pc + 64'd4);
      if (if_pc[1:0] == 2'b00)
        checkOutput("inst", 64'(if_inst), 64'(memData(if_pc)));
    end
  endtask

  task automatic stepN(input int n, input logic st);
    repeat (n) applyStimulus(1'b1, 1'b0, 64'h0, st);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    delivered.delete();
    reqCount = 0;
  endtask

  function automatic int countBelow(input logic [63:0] lim);
    int n = 0;
    foreach (delivered[i]) if (delivered[i] < lim) n++;
    return n;
  endfunction

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    stall           = 1'b0;
    next_pc         = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    cycNum          = 0;
    memLat          = 1;
    reqCount        = 0;
    assertCount     = 0;
    failCount       = 0;

    // Reset state, then zero-bubble streaming at 1-cycle latency.
    resetDut();
    checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_if_inst", 64'(if_inst), 64'd0);
    checkOutput("rst_if_pc", if_pc, 64'd0);
    checkOutput("rst_if_pc4", if_pc4, 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("c0_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("c0_req_addr", imem_req_addr, 64'h100);
    checkOutput("c0_if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("c1_req_addr", imem_req_addr, 64'h104);
    checkOutput("c1_if_valid", 64'(if_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("stream_valid", 64'(if_valid), 64'd1);
      checkOutput("stream_pc", if_pc, 64'h100 + 64'(4 * k));
    end

    // Stall from release: credits run out at DEPTH, outputs hold steady.
    resetDut();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
      if (k >= 2) begin
        checkOutput("stall_if_valid", 64'(if_valid), 64'd1);
        checkOutput("stall_if_pc", if_pc, 64'h100);
        checkOutput("stall_if_inst", 64'(if_inst), 64'(memData(64'h100)));
      end
    end
    checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("stall_req_count", 64'(reqCount), 64'd4);
    stepN(6, 1'b0);
    for (int k = 0; k < 4; k++)
      checkOutput("stall_drain_pc", delivered[k], 64'h100 + 64'(4 * k));

    // Flush with three requests outstanding: old responses are dropped.
    resetDut();
    memLat = 5;
    stepN(3, 1'b0);
    checkOutput("fl_outstanding", 64'(reqCount), 64'd3);
    applyStimulus(1'b1, 1'b1, 64'h2000, 1'b0);
    checkOutput("fl_cycle_req", 64'(imem_req_valid), 64'd0);
    checkOutput("fl_cycle_if_valid", 64'(if_valid), 64'd0);
    delivered.delete();
    stepN(12, 1'b0);
    checkOutput("fl_first_pc", delivered[0], 64'h2000);
    checkOutput("fl_second_pc", delivered[1], 64'h2004);
    checkOutput("fl_old_seen", 64'(countBelow(64'h2000)), 64'd0);

    // Back-to-back flushes with 4-cycle memory: last target wins.
    resetDut();
    memLat = 4;
    stepN(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h3000, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h4000, 1'b0);
    delivered.delete();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("b2b_req_addr", imem_req_addr, 64'h4000);
    stepN(16, 1'b0);
    checkOutput("b2b_first_pc", delivered[0], 64'h4000);
    checkOutput("b2b_second_pc", delivered[1], 64'h4004);
    checkOutput("b2b_old_seen", 64'(countBelow(64'h4000)), 64'd0);

    // Reset while flush is high and a response arrives.
    resetDut();
    memLat = 1;
    stepN(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h5000, 1'b0);
    checkOutput("rfl_resp_seen", 64'(imem_resp_valid), 64'd1);
    delivered.delete();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("rfl_if_valid", 64'(if_valid), 64'd0);
    checkOutput("rfl_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("rfl_req_addr", imem_req_addr, 64'h100);
    stepN(4, 1'b0);
    checkOutput("rfl_first_pc", delivered[0], 64'h100);

    // PC wrap at 2^64.
    resetDut();
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("wrap_req0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("wrap_req1", imem_req_addr, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_if_pc4", if_pc4, 64'h0);

`ifdef CORE_FETCH_MISALIGN_EN
    // Misaligned target: one zero marker entry, then no requests.
    resetDut();
    applyStimulus(1'b1, 1'b1, 64'h2002, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mis_req_valid", 64'(imem_req_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mis_if_valid", 64'(if_valid), 64'd1);
    checkOutput("mis_if_pc", if_pc, 64'h2002);
    checkOutput("mis_flag", 64'(if_misalign), 64'd1);
    checkOutput("mis_if_inst", 64'(if_inst), 64'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("mis_halt_req", 64'(imem_req_valid), 64'd0);
      checkOutput("mis_halt_valid", 64'(if_valid), 64'd0);
    end
    checkOutput("mis_req_count", 64'(reqCount), 64'd0);
    applyStimulus(1'b1, 1'b1, 64'h3000, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mis_resume_req", 64'(imem_req_valid), 64'd1);
    checkOutput("mis_resume_addr", imem_req_addr, 64'h3000);
    stepN(2, 1'b0);
    checkOutput("mis_resume_flag", 64'(if_misalign), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
